core_result_drain: RTL and testbench
====================================

Name: core_result_drain

Overview:
Receiving end of the core's result bus. Captures one full N_GROUP x N_UNIT accumulator tile from the core's flat `out` vector in a single cycle. Replays the tile one group row per beat on a valid/ready stream toward writeback or memory. Sits directly after `core`. Frees the core to start the next tile while the previous one drains.

Parameters:
N_GROUP, 16, rows (groups) per tile; must be a power of two, >= 2
N_UNIT, 16, accumulator units per row
DW_ADD, 32, accumulator width in bits
DW_CORE_OUT, DW_ADD*N_UNIT*N_GROUP, width of the captured tile (derived; do not override)
DW_ROW, DW_ADD*N_UNIT, width of one output beat (derived)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous, active-high reset
in_data  input  DW_CORE_OUT  tile from core; element j=g*N_UNIT+u at bits [j*DW_ADD +: DW_ADD]
in_valid  input  1  tile present on in_data this cycle
in_ready  output  1  block can capture a tile
out_data  output  DW_ROW  one row; unit u at bits [u*DW_ADD +: DW_ADD]
out_valid  output  1  out_data/out_row/out_last valid
out_ready  input  1  downstream accepts the beat
out_row  output  $clog2(N_GROUP)  row index of the current beat
out_last  output  1  marks the final beat of the tile
busy  output  1  tile held, drain in progress

Behaviour:
- One clock domain. All state updates on posedge clk.
- Synchronous reset: state=IDLE, row counter=0, tile register=0.
- Output values during reset: in_ready=0, out_valid=0, out_last=0, busy=0, out_row=0, out_data=0.
- FSM states:
  - IDLE: in_ready=1, out_valid=0. If in_valid=1, capture in_data into the tile register, clear the row counter, and go to SEND.
  - SEND: out_valid=1, out_row=row counter, out_data=tile row[row counter].
    - A beat is accepted when out_valid && out_ready.
    - On an accepted beat that is not the last row: increment the row counter.
    - On an accepted beat on the last data beat: go to IDLE.
  - CSUM: exists only with the optional feature (see below).
- Latency: capture edge -> row 0 on out_valid in the next cycle. Minimum of N_GROUP cycles from capture to IDLE.
- in_ready rules:
  - in_ready=1 only in IDLE.
  - in_valid while in_ready=0 is ignored; the core must hold or retry.
  - There is no same-cycle reload: after the last beat, in_ready rises in the following cycle.
- Backpressure:
  - While out_valid=1 && out_ready=0, out_data, out_row and out_last hold stable.
  - out_valid never drops without a handshake.
- out_last=1 only on the final beat: row N_GROUP-1, or the checksum beat when that is enabled.
- busy=1 in every state except IDLE.
- The row counter never wraps: the exit to IDLE happens at N_GROUP-1 (or after CSUM).
- Reset mid-drain: the tile is discarded, out_valid drops in the cycle after reset is sampled, and no further beats are issued.
- If reset and in_valid are both high, reset wins and nothing is captured.
- Data passes through bit-exact; there is no arithmetic on the data path.

Optional Feature:
Macro: DRAIN_CHECKSUM_EN.
- Defined:
  - During capture, also register a checksum: the sum of all N_GROUP*N_UNIT elements, modulo 2^DW_ADD, with two's-complement wrap.
  - After row N_GROUP-1 is accepted, enter CSUM for one extra beat:
    - out_data = {zeros, checksum} with the checksum in bits [DW_ADD-1:0];
    - out_row = 0;
    - out_last = 1.
  - Row N_GROUP-1 then has out_last=0.
  - A tile is N_GROUP+1 beats.
- Undefined:
  - No CSUM state and no adder tree.
  - A tile is N_GROUP beats, with out_last on row N_GROUP-1.

Test Plan:
1. Basic drain.
   - Stimulus: defaults; element j = j; one in_valid pulse; out_ready held at 1.
   - Response:
     - row 0 in the cycle after capture, with unit0 = 0;
     - row 15 with unit15 = 255 and out_last = 1;
     - 16 consecutive beats;
     - in_ready returns 1 one cycle after the last beat.
2. Backpressure.
   - Stimulus: hold out_ready=0 for 3 cycles while out_row=4.
   - Response:
     - out_data stays at row 4 (unit0 = 64) and does not change;
     - out_valid stays 1;
     - out_row advances to 5 only after out_ready=1.
3. Busy rejection.
   - Stimulus: while in SEND, present a second tile of all 0xFFFFFFFF with in_valid=1.
   - Response:
     - it is ignored;
     - all remaining beats come from the first tile.
4. Reset mid-drain.
   - Stimulus: assert reset for one cycle at out_row=5.
   - Response:
     - out_valid=0, busy=0 the next cycle;
     - in_ready=1 after reset is released;
     - a new tile drains starting from row 0.
5. Checksum.
   - Stimulus: DRAIN_CHECKSUM_EN defined, tile j = j.
   - Response:
     - 17 beats;
     - final beat out_data[31:0] = 32640 with out_last = 1;
     - row 15 has out_last = 0.
6. Negative data.
   - Stimulus: tile with every element = -1.
   - Response:
     - every unit reads 0xFFFFFFFF;
     - with the checksum enabled, the final beat reads 0xFFFFFF00 (-256).

Source files
------------

// File: rtl/core_result_drain.sv
// core_result_drain: captures a full accumulator tile from the core and replays it one row per beat on a valid/ready stream. Optional checksum beat under `DRAIN_CHECKSUM_EN`.
module core_result_drain #(
    parameter int N_GROUP     = 16,
    parameter int N_UNIT      = 16,
    parameter int DW_ADD      = 32,
    parameter int DW_CORE_OUT = DW_ADD * N_UNIT * N_GROUP,
    parameter int DW_ROW      = DW_ADD * N_UNIT
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [DW_CORE_OUT-1:0]     in_data,
    input  logic                       in_valid,
    output logic                       in_ready,
    output logic [DW_ROW-1:0]          out_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [$clog2(N_GROUP)-1:0] out_row,
    output logic                       out_last,
    output logic                       busy
);
    localparam int RW = $clog2(N_GROUP);

    typedef enum logic [1:0] {
        IDLE,
        SEND
`ifdef DRAIN_CHECKSUM_EN
        , CSUM
`endif
    } state_t;

    state_t state, state_nxt;
    logic [RW-1:0] row;
    logic [DW_CORE_OUT-1:0] tile;
    logic beat, last_row, send;

    assign beat     = out_valid && out_ready;
    assign last_row = row == RW'(N_GROUP - 1);
    assign send     = !reset && state == SEND;

`ifdef DRAIN_CHECKSUM_EN
    logic [DW_ADD-1:0] sum, csum;

    // two's-complement wrapping sum of every element of the incoming tile
    always_comb begin
        sum = '0;
        for (int j = 0; j < N_GROUP * N_UNIT; j++) sum = sum + in_data[j*DW_ADD +: DW_ADD];
    end

    // checksum is latched alongside the tile it describes
    always_ff @(posedge clk) begin
        if (reset) csum <= '0;
        else if (in_ready && in_valid) csum <= sum;
    end
`endif

    // state register
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else state <= state_nxt;
    end

    // next-state logic: a tile ends on the accepted last row (or on the checksum beat)
    always_comb begin
        state_nxt = IDLE;
        case (state)
            IDLE: state_nxt = in_valid ? SEND : IDLE;
`ifdef DRAIN_CHECKSUM_EN
            SEND: state_nxt = (beat && last_row) ? CSUM : SEND;
            CSUM: state_nxt = beat ? IDLE : CSUM;
`else
            SEND: state_nxt = (beat && last_row) ? IDLE : SEND;
`endif
            default: state_nxt = IDLE;
        endcase
    end

    // tile capture and row advance; the counter stops at the last row instead of wrapping
    always_ff @(posedge clk) begin
        if (reset) begin
            tile <= '0;
            row  <= '0;
        end else if (in_ready && in_valid) begin
            tile <= in_data;
            row  <= '0;
        end else if (state == SEND && beat && !last_row) begin
            row <= row + 1'b1;
        end
    end

    // outputs are forced idle while reset is asserted
    always_comb begin
        in_ready  = !reset && state == IDLE;
        out_valid = !reset && state != IDLE;
        busy      = out_valid;
        out_row   = send ? row : '0;
`ifdef DRAIN_CHECKSUM_EN
        out_data  = send ? tile[int'(row)*DW_ROW +: DW_ROW] : (out_valid ? DW_ROW'(csum) : '0);
        out_last  = out_valid && state == CSUM;
`else
        out_data  = send ? tile[int'(row)*DW_ROW +: DW_ROW] : '0;
        out_last  = send && last_row;
`endif
    end
endmodule

// File: tb/tb_core_result_drain.sv
// tb_core_result_drain: directed bench for core_result_drain (default parameters, either build of `DRAIN_CHECKSUM_EN`).
module tb_core_result_drain;
    localparam int NG   = 16;
    localparam int NU   = 16;
    localparam int DW   = 32;
    localparam int ROW  = DW * NU;
    localparam int TILE = ROW * NG;

    logic            clk = 0;
    logic            reset;
    logic [TILE-1:0] in_data;
    logic            in_valid;
    logic            in_ready;
    logic [ROW-1:0]  out_data;
    logic            out_valid;
    logic            out_ready;
    logic [3:0]      out_row;
    logic            out_last;
    logic            busy;

    int vectors = 0;
    int miscompares = 0;
    logic [TILE-1:0] seq_tile;

    core_result_drain dut (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .out_row(out_row),
        .out_last(out_last), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [ROW-1:0] got, input logic [ROW-1:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [ROW-1:0] seq_row(input int g);
        logic [ROW-1:0] r;
        for (int u = 0; u < NU; u++) r[u*DW +: DW] = DW'(g * NU + u);
        return r;
    endfunction

    task automatic check_beat(input string tag, input int g, input logic [ROW-1:0] exp);
        chk({tag, " valid"}, ROW'(out_valid), 1);
        chk({tag, " row"}, ROW'(out_row), ROW'(g));
        chk({tag, " data"}, out_data, exp);
`ifdef DRAIN_CHECKSUM_EN
        chk({tag, " last"}, ROW'(out_last), 0);
`else
        chk({tag, " last"}, ROW'(out_last), ROW'(g == NG - 1));
`endif
    endtask

    task automatic check_tail(input string tag, input logic [DW-1:0] cs);
`ifdef DRAIN_CHECKSUM_EN
        chk({tag, " csum valid"}, ROW'(out_valid), 1);
        chk({tag, " csum row"}, ROW'(out_row), 0);
        chk({tag, " csum data"}, out_data, ROW'(cs));
        chk({tag, " csum last"}, ROW'(out_last), 1);
        step;
`else
        chk({tag, " csum unused"}, ROW'(cs), ROW'(cs));
`endif
        chk({tag, " idle ready"}, ROW'(in_ready), 1);
        chk({tag, " idle valid"}, ROW'(out_valid), 0);
        chk({tag, " idle busy"}, ROW'(busy), 0);
    endtask

    task automatic capture(input logic [TILE-1:0] t);
        in_data  = t;
        in_valid = 1;
        step;
        in_valid = 0;
    endtask

    initial begin
        for (int j = 0; j < NG * NU; j++) seq_tile[j*DW +: DW] = DW'(j);
        reset = 1; in_valid = 0; out_ready = 0; in_data = '0;
        step; step;
        chk("rst in_ready", ROW'(in_ready), 0);
        chk("rst out_valid", ROW'(out_valid), 0);
        chk("rst busy", ROW'(busy), 0);
        chk("rst out_last", ROW'(out_last), 0);
        chk("rst out_row", ROW'(out_row), 0);
        chk("rst out_data", out_data, 0);
        reset = 0;
        #1;
        chk("post rst in_ready", ROW'(in_ready), 1);

        // basic drain, out_ready held high
        capture(seq_tile);
        out_ready = 1;
        chk("t1 row0 unit0", ROW'(out_data[DW-1:0]), 0);
        for (int g = 0; g < NG; g++) begin
            check_beat("t1", g, seq_row(g));
            if (g == NG - 1) chk("t1 row15 unit15", ROW'(out_data[ROW-1 -: DW]), 255);
            step;
        end
        check_tail("t1", 32'd32640);

        // backpressure at row 4 with a rejected second tile presented meanwhile
        capture(seq_tile);
        for (int g = 0; g < 4; g++) begin
            check_beat("t2", g, seq_row(g));
            step;
        end
        out_ready = 0;
        in_data   = '1;
        in_valid  = 1;
        for (int k = 0; k < 3; k++) begin
            check_beat("t2 stall", 4, seq_row(4));
            chk("t2 stall unit0", ROW'(out_data[DW-1:0]), 64);
            chk("t3 in_ready low", ROW'(in_ready), 0);
            chk("t2 busy", ROW'(busy), 1);
            step;
        end
        in_valid  = 0;
        out_ready = 1;
        for (int g = 4; g < NG; g++) begin
            check_beat("t3", g, seq_row(g));
            step;
        end
        check_tail("t3", 32'd32640);

        // reset in the middle of a drain, then a tile of all -1
        capture(seq_tile);
        for (int g = 0; g < 5; g++) begin
            check_beat("t4", g, seq_row(g));
            step;
        end
        chk("t4 at row5", ROW'(out_row), 5);
        reset = 1;
        step;
        reset = 0;
        #1;
        chk("t4 valid dropped", ROW'(out_valid), 0);
        chk("t4 busy dropped", ROW'(busy), 0);
        chk("t4 in_ready", ROW'(in_ready), 1);
        capture('1);
        for (int g = 0; g < NG; g++) begin
            check_beat("t6", g, '1);
            step;
        end
        check_tail("t6", 32'hFFFFFF00);

        // reset and in_valid together: nothing captured
        reset = 1; in_valid = 1; in_data = seq_tile;
        step;
        reset = 0; in_valid = 0;
        #1;
        chk("rst+valid no capture", ROW'(out_valid), 0);
        chk("rst+valid in_ready", ROW'(in_ready), 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
